// File: rtl/fixed_point_pkg.sv
// Shared types and constant helpers for the fixed-point multiplier family.
// Products are carried at the widest supported size and sign/zero-extended.
package fixed_point_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int PROD_W    = 2 * MAX_WIDTH;

  typedef struct packed {
    logic              valid;
    logic [PROD_W-1:0] product;
  } stage_t;

  function automatic logic [MAX_WIDTH-1:0] max_code(input int width, input bit sgn);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    if (sgn) r[width-1] = 1'b0;
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] min_code(input int width, input bit sgn);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    if (sgn) r[width-1] = 1'b1;
    return r;
  endfunction

  // Half an LSB of the scaled result; zero when there are no fractional bits.
  function automatic logic [PROD_W:0] round_const(input int frac);
    logic [PROD_W:0] r;
    r = '0;
    if (frac > 0) r[frac-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up, scale by FRAC and saturate/wrap to WIDTH bits.
// Input is a full product already sign- or zero-extended to PROD_W bits.
module fxp_round_sat
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [PROD_W-1:0] product,
  output logic [WIDTH-1:0]  res,
  output logic              ovf
);

  localparam logic [PROD_W:0]      RND  = round_const(FRAC);
  localparam logic [MAX_WIDTH-1:0] MAXC = max_code(WIDTH, SIGNED != 0);
  localparam logic [MAX_WIDTH-1:0] MINC = min_code(WIDTH, SIGNED != 0);

  logic [PROD_W:0] ext;
  logic [PROD_W:0] sum;
  logic [PROD_W:0] shifted;
  logic            fits;

  // One guard bit keeps the rounding add from overflowing.
  assign ext = {(SIGNED != 0) && product[PROD_W-1], product};
  assign sum = ext + RND;

  generate
    if (SIGNED != 0) begin : g_signed
      logic [PROD_W-WIDTH+1:0] hi;
      assign shifted = $unsigned($signed(sum) >>> FRAC);
      assign hi      = shifted[PROD_W:WIDTH-1];
      assign fits    = (hi == '0) || (&hi);
    end else begin : g_unsigned
      assign shifted = sum >> FRAC;
      assign fits    = (shifted[PROD_W:WIDTH] == '0);
    end
  endgenerate

  always_comb begin
    ovf = !fits;
    res = shifted[WIDTH-1:0];
    if (!fits && (SATURATE != 0)) begin
      if ((SIGNED != 0) && shifted[PROD_W]) res = MINC[WIDTH-1:0];
      else                                  res = MAXC[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_mult_pipe.sv
// Pipelined Q-format multiplier with rounding, saturation and overflow statistics.
// Latency STAGES cycles, 1 beat/cycle; whole pipe stalls when out_valid && !out_ready.
module fixed_point_mult_pipe
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int STAGES   = 3,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               NPROD   = STAGES - 2;

  logic              adv;
  logic              op_vld;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PROD_W-1:0] prod_c;
  stage_t            fin;
  logic [WIDTH-1:0]  rs_res;
  logic              rs_ovf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_vld <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (adv) begin
      op_vld <= in_valid;
      a_q    <= a;
      b_q    <= b;
    end
  end

  generate
    if (SIGNED != 0) begin : g_smul
      logic signed [2*WIDTH-1:0] ax;
      logic signed [2*WIDTH-1:0] bx;
      logic signed [2*WIDTH-1:0] px;
      assign ax     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      assign bx     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      assign px     = ax * bx;
      assign prod_c = PROD_W'(px);
    end else begin : g_umul
      logic [2*WIDTH-1:0] ax;
      logic [2*WIDTH-1:0] bx;
      logic [2*WIDTH-1:0] px;
      assign ax     = {{WIDTH{1'b0}}, a_q};
      assign bx     = {{WIDTH{1'b0}}, b_q};
      assign px     = ax * bx;
      assign prod_c = PROD_W'(px);
    end
  endgenerate

  // Trailing product registers are plain delays so synthesis can retime the multiplier into them.
  generate
    if (NPROD == 0) begin : g_direct
      assign fin = '{valid: op_vld, product: prod_c};
    end else begin : g_pipe
      stage_t pipe [NPROD];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NPROD; i++) pipe[i] <= '0;
        end else if (adv) begin
          pipe[0] <= '{valid: op_vld, product: prod_c};
          for (int i = 1; i < NPROD; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign fin = pipe[NPROD-1];
    end
  endgenerate

  fxp_round_sat #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_round_sat (
    .product (fin.product),
    .res     (rs_res),
    .ovf     (rs_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= fin.valid;
      result    <= rs_res;
      ovf       <= fin.valid && rs_ovf;
    end
  end

  // clr wins over a same-cycle overflow event, which is then dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (out_valid && out_ready && ovf) begin
      ovf_sticky <= 1'b1;
      if (sat_count != CNT_MAX) sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fixed_point_mult_pipe.sv
// Directed bench: Q16.16 signed multiplier, saturating instance plus a wrapping
// instance with a 2-bit counter sharing the same stimulus.
module tb_fixed_point_mult_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;
  logic        clr;

  logic        in_ready, out_valid, ovf, ovf_sticky;
  logic [31:0] result;
  logic [15:0] sat_count;

  logic        in_ready_w, out_valid_w, ovf_w, ovf_sticky_w;
  logic [31:0] result_w;
  logic [1:0]  sat_count_w;

  int checks;
  int errors;

  fixed_point_mult_pipe #(
    .WIDTH(32), .FRAC(16), .STAGES(3), .SIGNED(1), .SATURATE(1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky),
    .sat_count(sat_count), .clr(clr)
  );

  fixed_point_mult_pipe #(
    .WIDTH(32), .FRAC(16), .STAGES(3), .SIGNED(1), .SATURATE(0), .CNT_W(2)
  ) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .ovf(ovf_w), .ovf_sticky(ovf_sticky_w),
    .sat_count(sat_count_w), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat into an empty pipe and captures the first result of both instances.
  task automatic run_single(input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic o,
                            output logic [31:0] rw, output logic ow, output int lat);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; o = ovf; rw = result_w; ow = ovf_w;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", ovf_sticky); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL reset_sat_count got %0d exp 0", sat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] r, rw; logic o, ow; int lat;
    run_single(32'h00018000, 32'h00020000, r, o, rw, ow, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", lat); end
    checks++; if (r !== 32'h00030000) begin errors++; $display("FAIL basic_result got %h exp 00030000", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", o); end
  endtask

  task automatic test_negative;
    logic [31:0] r, rw; logic o, ow; int lat;
    run_single(32'hFFFE8000, 32'h00020000, r, o, rw, ow, lat);
    checks++; if (r !== 32'hFFFD0000) begin errors++; $display("FAIL negative_result got %h exp FFFD0000", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL negative_ovf got %b exp 0", o); end
  endtask

  task automatic test_rounding;
    logic [31:0] r, rw; logic o, ow; int lat;
    run_single(32'h00000001, 32'h00008000, r, o, rw, ow, lat);
    checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL round_half_up got %h exp 00000001", r); end
    run_single(32'h00000001, 32'h00007FFF, r, o, rw, ow, lat);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL round_below_half got %h exp 00000000", r); end
    run_single(32'hFFFFFFFF, 32'h00008000, r, o, rw, ow, lat);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL round_neg_half got %h exp 00000000", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL round_neg_half_ovf got %b exp 0", o); end
  endtask

  task automatic test_saturation;
    logic [31:0] r, rw; logic o, ow; int lat;
    logic [31:0] va [6] = '{32'h7FFF0000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h40000000};
    logic [31:0] vb [6] = '{32'h00020000, 32'h00020000, 32'hFFFF0000, 32'h00010000, 32'h00020000, 32'h00020000};
    logic [31:0] es [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] ew [6] = '{32'hFFFE0000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    logic        eo [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_single(va[i], vb[i], r, o, rw, ow, lat);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL sat_result[%0d] got %h exp %h", i, r, es[i]); end
      checks++; if (o !== eo[i]) begin errors++; $display("FAIL sat_ovf[%0d] got %b exp %b", i, o, eo[i]); end
      checks++; if (rw !== ew[i]) begin errors++; $display("FAIL wrap_result[%0d] got %h exp %h", i, rw, ew[i]); end
      checks++; if (ow !== eo[i]) begin errors++; $display("FAIL wrap_ovf[%0d] got %b exp %b", i, ow, eo[i]); end
      if (i == 0) begin
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b exp 1", ovf_sticky); end
        checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL sat_count_first got %0d exp 1", sat_count); end
      end
    end
    checks++; if (sat_count !== 16'd4) begin errors++; $display("FAIL sat_count_total got %0d exp 4", sat_count); end
    checks++; if (sat_count_w !== 2'd3) begin errors++; $display("FAIL sat_count_saturates got %0d exp 3", sat_count_w); end
  endtask

  task automatic test_back_to_back;
    int got, first, last;
    got = 0; first = -1; last = -1;
    b = 32'h00020000;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 4);
      a = (32'(c) << 16) | 32'h00008000;
      #1;
      if (out_valid) begin
        checks++;
        if (result !== (32'(2 * got + 1) << 16)) begin
          errors++; $display("FAIL b2b_result[%0d] got %h exp %h", got, result, 32'(2 * got + 1) << 16);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got); end
    checks++; if (last - first !== 3) begin errors++; $display("FAIL b2b_throughput span got %0d exp 3", last - first); end
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first_cycle got %0d exp 3", first); end
  endtask

  task automatic test_backpressure;
    int sent, got, stall_cycles, first_stall, unstable, extra;
    logic held_v;
    logic [31:0] held;
    sent = 0; got = 0; stall_cycles = 0; first_stall = -1; unstable = 0; held_v = 1'b0; held = '0;
    b = 32'h00030000;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 2 && c <= 7);
      in_valid  = (sent < 6);
      a = 32'(sent + 1) << 16;
      #1;
      if (held_v && (!out_valid || result !== held)) unstable++;
      held_v = out_valid && !out_ready;
      held   = result;
      if (!in_ready) begin
        stall_cycles++;
        if (first_stall < 0) first_stall = c;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (result !== (32'((got + 1) * 3) << 16)) begin
          errors++; $display("FAIL bp_result[%0d] got %h exp %h", got, result, 32'((got + 1) * 3) << 16);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_count got %0d exp 6", got); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp_duplicates got %0d exp 0", extra); end
    checks++; if (first_stall !== 3) begin errors++; $display("FAIL bp_in_ready_drop cycle got %0d exp 3", first_stall); end
    checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 5", stall_cycles); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", unstable); end
  endtask

  task automatic test_clear;
    int waitc;
    a = 32'h7FFF0000; b = 32'h00020000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    checks++; if (!(out_valid && ovf)) begin errors++; $display("FAIL clr_precondition got %b%b exp 11", out_valid, ovf); end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_handshake got %b exp 0", out_valid); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_sat_count got %0d exp 0", sat_count); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b exp 0", ovf_sticky); end
    checks++; if (sat_count_w !== 2'd0) begin errors++; $display("FAIL clr_sat_count_w got %0d exp 0", sat_count_w); end
  endtask

  task automatic test_reset_inflight;
    logic [31:0] r, rw; logic o, ow; int lat, stale;
    out_ready = 1'b0;
    a = 32'h00018000; b = 32'h00020000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h00010000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_precondition got %b exp 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_reset_result got %h exp 00000000", result); end
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL stale_after_reset got %0d exp 0", stale); end
    run_single(32'h00018000, 32'h00020000, r, o, rw, ow, lat);
    checks++; if (r !== 32'h00030000) begin errors++; $display("FAIL post_reset_result got %h exp 00030000", r); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got %0d exp 3", lat); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    test_reset();
    test_basic();
    test_negative();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_point_mult_pipe.md
Name: fixed_point_mult_pipe

Overview:
- Parametrised, pipelined fixed-point multiplier with valid/ready handshake, selectable signed/unsigned mode, rounding and saturation.
- Next-generation replacement for the fixed-latency multiplier IP wrapper.
- Feeds the SCARA kinematics datapath (joint-angle products, trig-table scaling).
- Adds a sticky overflow flag and a saturation-event counter for debug.

Parameters:
- WIDTH, 32: operand and result width in bits (8..64).
- FRAC, 16: fractional bits in the Q-format; 0 means pure integer (0..WIDTH-1).
- STAGES, 3: pipeline latency in cycles, minimum 2.
- SIGNED, 1: 1 = two's complement operands and result; 0 = unsigned.
- SATURATE, 1: 1 = clamp out-of-range results; 0 = wrap (truncate).
- CNT_W, 16: width of the saturation-event counter.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operands a and b are valid.
- in_ready, output, 1: block accepts operands this cycle.
- a, input, WIDTH: multiplicand, Q(WIDTH-FRAC).FRAC.
- b, input, WIDTH: multiplier, same format as a.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: downstream accepts the result.
- result, output, WIDTH: rounded, scaled product.
- ovf, output, 1: result for this beat was saturated or wrapped; qualified by out_valid.
- ovf_sticky, output, 1: set by any accepted overflowed beat; cleared by clr.
- sat_count, output, CNT_W: number of overflowed beats delivered.
- clr, input, 1: synchronous clear of ovf_sticky and sat_count.

Behaviour:
- Reset (reset low, asynchronous): all stage valid bits 0, out_valid 0, result 0, ovf 0, ovf_sticky 0, sat_count 0.
  - In-flight data is discarded.
  - First accept is possible on the first clk edge after reset deasserts.
- Pipeline advance: the whole pipeline uses one enable, adv = !out_valid || out_ready.
  - in_ready = adv, combinational; no path from in_valid to in_ready.
  - An input is accepted on an edge where in_valid && in_ready.
- Stage valid bits shift on adv; bubbles (in_valid low) propagate as valid = 0.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles later when out_ready stays high. Throughput is 1 beat per cycle.
- Stall: with out_ready low and out_valid high, all stages hold and in_ready is 0.
  - result and ovf stay stable until the handshake completes.
  - Capacity equals STAGES beats.
- Stage allocation:
  - Stage 1 registers the operands.
  - Stages 2..STAGES-1 form the 2*WIDTH full product, signed or unsigned per SIGNED, with register retiming allowed.
  - Final stage does round, shift, saturate.
  - When STAGES = 2, the product and final-stage logic share stage 2.
- Rounding (FRAC > 0):
  - Add 2^(FRAC-1) to the 2*WIDTH product.
  - Then shift right by FRAC: arithmetic shift if SIGNED, logical otherwise.
  - This is round-half-toward-+infinity. For FRAC = 0 there is no rounding.
- Range check: the shifted value must fit WIDTH bits, signed or unsigned per SIGNED. The rounding add must not overflow internally; use 2*WIDTH+1 bits.
- Out of range with SATURATE = 1: result is the max or min code.
  - Signed: 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - Unsigned: 2^WIDTH-1.
  - ovf = 1.
- Out of range with SATURATE = 0: result is the low WIDTH bits and ovf = 1.
- Counters: on an output handshake (out_valid && out_ready) with ovf = 1, ovf_sticky is set and sat_count increments, saturating at 2^CNT_W-1 with no wrap.
- clr behaviour:
  - clr has priority over a same-cycle increment: the result is 0, and that event is lost.
  - clr does not affect the datapath.
- Output timing: result, ovf and out_valid are registered outputs.

Decomposition:
- Package fixed_point_pkg:
  - typedef for the stage record {valid, product, ...}.
  - Functions for max/min code per WIDTH/SIGNED.
  - Rounding-constant function.
  - Localparams PROD_W = 2*WIDTH and CNT_MAX.
- Sub-module fxp_round_sat: combinational round, shift and saturate for the final stage. It is reused by the future accumulator block.
- Pipeline control and counters stay in the top module.

Test Plan (WIDTH=32, FRAC=16, STAGES=3, SIGNED=1, SATURATE=1 unless noted):
- Basic product: a=0x00018000 (1.5), b=0x00020000 (2.0), out_ready=1 → result=0x00030000, ovf=0, exactly 3 cycles after accept.
- Negative product: a=0xFFFE8000 (-1.5), b=0x00020000 → 0xFFFD0000.
- Rounding: a=0x00000001, b=0x00008000 (product 0x8000) → 0x00000001.
- Negative half: a=0xFFFFFFFF, b=0x00008000 → 0x00000000.
- Saturation: a=0x7FFF0000, b=0x00020000 → 0x7FFFFFFF, ovf=1, ovf_sticky=1, sat_count=1.
  - Repeat with SATURATE=0: result=0xFFFE0000 with ovf=1.
- Backpressure: stream 6 beats with out_ready low from cycle 2 to cycle 7.
  - in_ready drops once 3 beats are held; result stays stable during the stall.
  - All 6 results arrive in order with no loss or duplication.
- Reset and clear:
  - Pull reset low with 2 beats in flight: out_valid is 0 immediately (asynchronously); no stale beat after release.
  - clr asserted in the same cycle as an overflowed handshake: sat_count=0.
